// File: rtl/dht11_emulator.sv
// rtl/dht11_emulator.sv - DHT11 sensor-side responder for single-wire bench/HIL use
`timescale 1ns/1ps
//
// Purpose:
//   Plays the sensor half of the DHT11 single-wire protocol on an open-drain line.
//   A host low pulse of at least START_MIN_US starts a frame. The block then sends
//   the 80/80 response and 40 data bits, MSB first:
//   {hum_int, hum_dec, temp_int, temp_dec, chk}.
//
// Ports:
//   clk          system clock (CLK_PER_US cycles per microsecond)
//   rst_n        synchronous reset, active HIGH despite the name
//   dht_data     open-drain data line (driven 0 or released)
//   hum_int/hum_dec/temp_int/temp_dec  payload bytes, latched at start acceptance
//   corrupt_chk  flips checksum bit 0 when latched high
//   busy         high from start acceptance until end of frame
//   frame_done   one-cycle pulse at frame completion
//   err_short    one-cycle pulse when a host low pulse is too short
//   frame_count  completed frames, wraps at 16 bits

module dht11_emulator #(
  parameter int CLK_PER_US   = 1,
  parameter int START_MIN_US = 18000,
  parameter int RESP_WAIT_US = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire         dht_data,
  input  logic [7:0]  hum_int,
  input  logic [7:0]  hum_dec,
  input  logic [7:0]  temp_int,
  input  logic [7:0]  temp_dec,
  input  logic        corrupt_chk,
  output logic        busy,
  output logic        frame_done,
  output logic        err_short,
  output logic [15:0] frame_count
);

  localparam int START_CYC = START_MIN_US * CLK_PER_US;
  localparam int WAIT_CYC  = RESP_WAIT_US * CLK_PER_US;
  localparam int RESP_CYC  = 80 * CLK_PER_US;
  localparam int BITL_CYC  = 50 * CLK_PER_US;
  localparam int ZERO_CYC  = 26 * CLK_PER_US;
  localparam int ONE_CYC   = 70 * CLK_PER_US;

  // Counter must hold the start threshold and the longest timed phase.
  localparam int MAX_A   = (START_CYC > RESP_CYC) ? START_CYC : RESP_CYC;
  localparam int MAX_CYC = (MAX_A > WAIT_CYC) ? MAX_A : WAIT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 2);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] START_MIN  = CNT_W'(START_CYC);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] RESP_LAST  = CNT_W'(RESP_CYC - 1);
  localparam logic [CNT_W-1:0] BITL_LAST  = CNT_W'(BITL_CYC - 1);
  localparam logic [CNT_W-1:0] ZERO_LAST  = CNT_W'(ZERO_CYC - 1);
  localparam logic [CNT_W-1:0] ONE_LAST   = CNT_W'(ONE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_LOW,
    S_WAIT_RESP,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_END_LOW
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [5:0]        r_idx;
  logic [39:0]       r_frame;
  logic              r_drive_low;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_err_short;
  logic [15:0]       r_frame_count;

  logic              r_sync1;
  logic              r_din_s;
  logic              r_din_d;

  logic              w_fall;
  logic              w_rise;
  logic [7:0]        w_chk;
  logic [CNT_W-1:0]  w_bit_last;

  assign dht_data = r_drive_low ? 1'b0 : 1'bz;

  // Two-flop synchronizer plus one delay stage for edge detection. Reset to the
  // released (high) level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_sync1 <= 1'b1;
      r_din_s <= 1'b1;
      r_din_d <= 1'b1;
    end else begin
      r_sync1 <= dht_data;
      r_din_s <= r_sync1;
      r_din_d <= r_din_s;
    end
  end

  assign w_fall = r_din_d & ~r_din_s;
  assign w_rise = ~r_din_d & r_din_s;

  // Modulo-256 sum: the 8-bit result is the truncated wide sum.
  assign w_chk = (hum_int + hum_dec + temp_int + temp_dec) ^ {7'd0, corrupt_chk};

  assign w_bit_last = r_frame[r_idx] ? ONE_LAST : ZERO_LAST;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_idx         <= 6'd0;
      r_frame       <= 40'd0;
      r_drive_low   <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err_short   <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_frame_done <= 1'b0;
      r_err_short  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // The completion cycle ignores edges so a start always needs a fresh fall.
          if (w_fall && !r_frame_done) begin
            r_state <= S_START_LOW;
            r_cnt   <= '0;
          end
        end

        S_START_LOW: begin
          if (w_rise) begin
            r_cnt <= '0;
            if (r_cnt >= START_MIN) begin
              r_state <= S_WAIT_RESP;
              r_busy  <= 1'b1;
              r_frame <= {hum_int, hum_dec, temp_int, temp_dec, w_chk};
            end else begin
              r_state     <= S_IDLE;
              r_err_short <= 1'b1;
            end
          end else if (!r_din_s && r_cnt != CNT_MAX) begin
            // Saturate so a very long host pulse cannot wrap into a short one.
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_WAIT_RESP: begin
          if (r_cnt == WAIT_LAST) begin
            r_state     <= S_RESP_LOW;
            r_cnt       <= '0;
            r_drive_low <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_RESP_LOW: begin
          if (r_cnt == RESP_LAST) begin
            r_state     <= S_RESP_HIGH;
            r_cnt       <= '0;
            r_drive_low <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_RESP_HIGH: begin
          if (r_cnt == RESP_LAST) begin
            r_state     <= S_BIT_LOW;
            r_cnt       <= '0;
            r_idx       <= 6'd39;
            r_drive_low <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_BIT_LOW: begin
          if (r_cnt == BITL_LAST) begin
            r_state     <= S_BIT_HIGH;
            r_cnt       <= '0;
            r_drive_low <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_BIT_HIGH: begin
          // Bit value is encoded purely by the length of this released phase.
          if (r_cnt == w_bit_last) begin
            r_cnt       <= '0;
            r_drive_low <= 1'b1;
            if (r_idx == 6'd0) begin
              r_state <= S_END_LOW;
            end else begin
              r_state <= S_BIT_LOW;
              r_idx   <= r_idx - 6'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_END_LOW: begin
          if (r_cnt == BITL_LAST) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_drive_low   <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_drive_low <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign err_short   = r_err_short;
  assign frame_count = r_frame_count;

endmodule
